mux: RTL and testbench

Registered 2:1 datapath selector used in the processor core to steer one of two WIDTH-bit operands onto a single registered output. The choice is made by a 1-bit select qualified by an enable. The first single-bit ALU result bit drives `sel`; the program-counter enable drives `en`. The block adds a one-cycle pipeline register, a valid flag and a source-switch pulse so downstream stages can tell fresh data from held data.

---
 rtl/mux.sv | 46 ++++
 tb/tb_mux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/mux.sv
// Registered 2:1 operand selector with a valid flag and a source-switch pulse.
// Downstream stages use y_valid and sw to tell freshly captured data from held data.
module mux #(
    parameter int               WIDTH   = 32,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sel,
    input  logic             en,
    output logic [WIDTH-1:0] y,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    output logic             y_valid,
    output logic             sel_q,
    output logic             sw
);

    logic [WIDTH-1:0] y_p1;
    logic             vld_p1;
    logic             sel_p1;
    logic             sw_p1;

    // Stage p1: capture register; hold keeps data and select, but sw lasts only one cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            y_p1   <= RST_VAL;
            vld_p1 <= 1'b0;
            sel_p1 <= 1'b0;
            sw_p1  <= 1'b0;
        end else if (en) begin
            y_p1   <= sel ? d1 : d0;
            sel_p1 <= sel;
            vld_p1 <= 1'b1;
            sw_p1  <= vld_p1 && (sel != sel_p1);
        end else begin
            sw_p1  <= 1'b0;
        end
    end

    assign y       = y_p1;
    assign y_valid = vld_p1;
    assign sel_q   = sel_p1;
    assign sw      = sw_p1;

endmodule

// File: tb/tb_mux.sv
// Directed bench for the registered 2:1 selector, one task per scenario.
// A second narrow instance with a non-zero reset value checks RST_VAL handling.
module tb_mux;

    logic        clk;
    logic        rst;
    logic        sel;
    logic        en;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [31:0] y;
    logic        y_valid;
    logic        sel_q;
    logic        sw;
    logic [7:0]  y8;
    logic        y_valid8;
    logic        sel_q8;
    logic        sw8;

    int tests;
    int fails;

    mux #(.WIDTH(32), .RST_VAL(32'h0)) u_dut (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .y(y),
        .d0(d0), .d1(d1), .y_valid(y_valid), .sel_q(sel_q), .sw(sw)
    );

    mux #(.WIDTH(8), .RST_VAL(8'h5A)) u_dut8 (
        .clk(clk), .rst(rst), .sel(sel), .en(en), .y(y8),
        .d0(d0[7:0]), .d1(d1[7:0]), .y_valid(y_valid8), .sel_q(sel_q8), .sw(sw8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; sel = 1'b1; d0 = 32'h0; d1 = 32'hFFFF_FFFF;
        step();
        step();
        tests++; if (y !== 32'h0) begin fails++; $display("FAIL reset_y actual=%h expected=%h", y, 32'h0); end
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL reset_valid actual=%b expected=0", y_valid); end
        tests++; if (sel_q !== 1'b0) begin fails++; $display("FAIL reset_sel_q actual=%b expected=0", sel_q); end
        tests++; if (sw !== 1'b0) begin fails++; $display("FAIL reset_sw actual=%b expected=0", sw); end
        tests++; if (y8 !== 8'h5A) begin fails++; $display("FAIL reset_y8 actual=%h expected=5a", y8); end
    endtask

    task automatic test_basic_select();
        rst = 1'b0; d0 = 32'h1234_5678; d1 = 32'hDEAD_BEEF;
        en = 1'b1; sel = 1'b0;
        step();
        tests++; if (y !== 32'h1234_5678) begin fails++; $display("FAIL basic_y0 actual=%h expected=12345678", y); end
        tests++; if (sw !== 1'b0) begin fails++; $display("FAIL basic_sw0 actual=%b expected=0", sw); end
        tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL basic_valid actual=%b expected=1", y_valid); end
        tests++; if (y8 !== 8'h78) begin fails++; $display("FAIL basic_y8 actual=%h expected=78", y8); end
        sel = 1'b1;
        step();
        tests++; if (y !== 32'hDEAD_BEEF) begin fails++; $display("FAIL basic_y1 actual=%h expected=deadbeef", y); end
        tests++; if (sw !== 1'b1) begin fails++; $display("FAIL basic_sw1 actual=%b expected=1", sw); end
        tests++; if (sel_q !== 1'b1) begin fails++; $display("FAIL basic_sel_q actual=%b expected=1", sel_q); end
    endtask

    task automatic test_hold();
        en = 1'b0; d1 = 32'h0; sel = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++; if (y !== 32'hDEAD_BEEF) begin fails++; $display("FAIL hold_y[%0d] actual=%h expected=deadbeef", i, y); end
            tests++; if (sel_q !== 1'b1) begin fails++; $display("FAIL hold_sel_q[%0d] actual=%b expected=1", i, sel_q); end
            tests++; if (sw !== 1'b0) begin fails++; $display("FAIL hold_sw[%0d] actual=%b expected=0", i, sw); end
            tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL hold_valid[%0d] actual=%b expected=1", i, y_valid); end
        end
    endtask

    task automatic test_same_source();
        d0 = 32'h0BAD_F00D; d1 = 32'h5555_AAAA; en = 1'b1; sel = 1'b1;
        step();
        step();
        tests++; if (y !== 32'h5555_AAAA) begin fails++; $display("FAIL same_y actual=%h expected=5555aaaa", y); end
        tests++; if (sw !== 1'b0) begin fails++; $display("FAIL same_sw actual=%b expected=0", sw); end
    endtask

    task automatic test_first_capture();
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; sel = 1'b1; d1 = 32'hA5A5_A5A5;
        step();
        tests++; if (sw !== 1'b0) begin fails++; $display("FAIL first_sw actual=%b expected=0", sw); end
        tests++; if (y !== 32'hA5A5_A5A5) begin fails++; $display("FAIL first_y actual=%h expected=a5a5a5a5", y); end
        tests++; if (sel_q !== 1'b1) begin fails++; $display("FAIL first_sel_q actual=%b expected=1", sel_q); end
        tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL first_valid actual=%b expected=1", y_valid); end
    endtask

    task automatic test_alternating();
        logic [31:0] exp_y [4];
        logic        exp_sw [4];
        exp_y[0] = 32'h1111_1111; exp_y[1] = 32'h2222_2222;
        exp_y[2] = 32'h1111_1111; exp_y[3] = 32'h2222_2222;
        exp_sw[0] = 1'b0; exp_sw[1] = 1'b1; exp_sw[2] = 1'b1; exp_sw[3] = 1'b1;
        rst = 1'b1; en = 1'b0;
        step();
        rst = 1'b0; en = 1'b1; d0 = 32'h1111_1111; d1 = 32'h2222_2222;
        for (int i = 0; i < 4; i++) begin
            sel = i[0];
            step();
            tests++; if (y !== exp_y[i]) begin fails++; $display("FAIL alt_y[%0d] actual=%h expected=%h", i, y, exp_y[i]); end
            tests++; if (sw !== exp_sw[i]) begin fails++; $display("FAIL alt_sw[%0d] actual=%b expected=%b", i, sw, exp_sw[i]); end
        end
    endtask

    task automatic test_mid_reset();
        rst = 1'b0; en = 1'b1; d0 = 32'h3333_3333; d1 = 32'h4444_4444;
        sel = 1'b0;
        step();
        sel = 1'b1;
        step();
        tests++; if (sw !== 1'b1) begin fails++; $display("FAIL mid_pre_sw actual=%b expected=1", sw); end
        rst = 1'b1; sel = 1'b0;
        step();
        tests++; if (y !== 32'h0) begin fails++; $display("FAIL mid_rst_y actual=%h expected=0", y); end
        tests++; if (y_valid !== 1'b0) begin fails++; $display("FAIL mid_rst_valid actual=%b expected=0", y_valid); end
        tests++; if (sw !== 1'b0) begin fails++; $display("FAIL mid_rst_sw actual=%b expected=0", sw); end
        tests++; if (sel_q !== 1'b0) begin fails++; $display("FAIL mid_rst_sel_q actual=%b expected=0", sel_q); end
        tests++; if (y8 !== 8'h5A) begin fails++; $display("FAIL mid_rst_y8 actual=%h expected=5a", y8); end
        rst = 1'b0; sel = 1'b1;
        step();
        tests++; if (sw !== 1'b0) begin fails++; $display("FAIL mid_next_sw actual=%b expected=0", sw); end
        tests++; if (y_valid !== 1'b1) begin fails++; $display("FAIL mid_next_valid actual=%b expected=1", y_valid); end
        tests++; if (y !== 32'h4444_4444) begin fails++; $display("FAIL mid_next_y actual=%h expected=44444444", y); end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; en = 1'b0; sel = 1'b0; d0 = 32'h0; d1 = 32'h0;
        test_reset();
        test_basic_select();
        test_hold();
        test_same_source();
        test_first_capture();
        test_alternating();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
